cross_product_arbiter: RTL and testbench

//  Shares one pipelined signed cross-product unit among NUM_REQ requesters, e.g. the polygon

---
 rtl/cross_product_arbiter.sv | 173 +++++++++++++++++
 tb/tb_cross_product_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cross_product_arbiter.sv
// cross_product_arbiter
//   Shares one pipelined signed 2-D cross-product unit among NUM_REQ requesters.
//   A round-robin arbiter grants one requester per cycle. The unit computes
//   (P1x-Rx)*(P2y-Ry) - (P2x-Rx)*(P1y-Ry) over three registered stages and
//   returns the result tagged with the owner's one-hot id, LATENCY=3 after acceptance.
// Ports
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   flush           synchronous kill of all in-flight work; blocks acceptance that cycle
//   req             per-requester request; held with operands until granted
//   req_ref/p1/p2   per-requester points, packed {x,y}, COORD_W unsigned each
//   gnt             one-hot grant, combinational
//   rsp_valid       one-hot owner of the result, 1-cycle pulse
//   rsp_result      signed cross product, holds when rsp_valid=0
//   rsp_ge0         rsp_result >= 0
//   busy            any stage holds a valid operation

// Signed difference of two unsigned coordinates, one bit wider than the inputs.
module cross_product_arbiter_sdiff #(
  parameter int W = 10
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W:0]   d
);
  assign d = {1'b0, a} - {1'b0, b};
endmodule

module cross_product_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int COORD_W = 10,
  parameter int RES_W   = 2*COORD_W+2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 flush,
  input  logic [NUM_REQ-1:0]                   req,
  input  logic [NUM_REQ-1:0][2*COORD_W-1:0]    req_ref,
  input  logic [NUM_REQ-1:0][2*COORD_W-1:0]    req_p1,
  input  logic [NUM_REQ-1:0][2*COORD_W-1:0]    req_p2,
  output logic [NUM_REQ-1:0]                   gnt,
  output logic [NUM_REQ-1:0]                   rsp_valid,
  output logic [RES_W-1:0]                     rsp_result,
  output logic                                 rsp_ge0,
  output logic                                 busy
);
  localparam int STAGES = 3;
  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DW     = COORD_W + 1;
  localparam int LANES  = 4;

  // ---------------------------------------------------------------- arbiter
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] gidx;
  logic             accept;

  // Scan from ptr with wrap-around; first requesting slot wins.
  always_comb begin
    int               idx;
    logic [PTR_W-1:0] ix;
    idx    = 0;
    ix     = '0;
    gnt    = '0;
    gidx   = '0;
    accept = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      ix = PTR_W'(idx);
      if (!accept && req[ix]) begin
        accept = 1'b1;
        gidx   = ix;
      end
    end
    if (flush || reset) accept = 1'b0;
    if (accept) gnt[gidx] = 1'b1;
  end

  logic [PTR_W-1:0] ptr_nxt;
  assign ptr_nxt = (gidx == PTR_W'(NUM_REQ-1)) ? '0 : gidx + PTR_W'(1);

  // ---------------------------------------------------------------- S1 lanes
  // Lane order: 0 = P1x-Rx, 1 = P2y-Ry, 2 = P2x-Rx, 3 = P1y-Ry.
  logic [2*COORD_W-1:0]           sel_r, sel_1, sel_2;
  logic [LANES-1:0][COORD_W-1:0]  lane_a, lane_b;
  logic [LANES-1:0][DW-1:0]       lane_d;

  assign sel_r = req_ref[gidx];
  assign sel_1 = req_p1[gidx];
  assign sel_2 = req_p2[gidx];

  assign lane_a[0] = sel_1[2*COORD_W-1:COORD_W];
  assign lane_b[0] = sel_r[2*COORD_W-1:COORD_W];
  assign lane_a[1] = sel_2[COORD_W-1:0];
  assign lane_b[1] = sel_r[COORD_W-1:0];
  assign lane_a[2] = sel_2[2*COORD_W-1:COORD_W];
  assign lane_b[2] = sel_r[2*COORD_W-1:COORD_W];
  assign lane_a[3] = sel_1[COORD_W-1:0];
  assign lane_b[3] = sel_r[COORD_W-1:0];

  for (genvar l = 0; l < LANES; l++) begin : g_diff
    cross_product_arbiter_sdiff #(.W(COORD_W)) u_diff (
      .a (lane_a[l]),
      .b (lane_b[l]),
      .d (lane_d[l])
    );
  end

  // ---------------------------------------------------------------- pipeline
  logic [STAGES:1]               vld_pipe;
  logic [LANES-1:0][DW-1:0]      s1_d;
  logic [NUM_REQ-1:0]            s1_tag;
  logic [RES_W-1:0]              s2_pa, s2_pb;
  logic [NUM_REQ-1:0]            s2_tag;

  // Sign-extend the differences to full product width so the multiply is
  // exact without relying on context-width extension.
  logic [RES_W-1:0] ext_d [LANES];
  for (genvar l = 0; l < LANES; l++) begin : g_ext
    assign ext_d[l] = {{(RES_W-DW){s1_d[l][DW-1]}}, s1_d[l]};
  end

  logic [RES_W-1:0] pa_c, pb_c, res_c;
  assign pa_c  = $signed(ext_d[0]) * $signed(ext_d[1]);
  assign pb_c  = $signed(ext_d[2]) * $signed(ext_d[3]);
  assign res_c = s2_pa - s2_pb;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr        <= '0;
      vld_pipe   <= '0;
      s1_d       <= '0;
      s1_tag     <= '0;
      s2_pa      <= '0;
      s2_pb      <= '0;
      s2_tag     <= '0;
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_ge0    <= 1'b0;
    end else begin
      if (accept) ptr <= ptr_nxt;

      // flush drops everything in flight; accept is already 0 in that cycle.
      if (flush) begin
        vld_pipe  <= '0;
        rsp_valid <= '0;
      end else begin
        vld_pipe  <= {vld_pipe[STAGES-1:1], accept};
        rsp_valid <= vld_pipe[2] ? s2_tag : '0;
      end

      if (accept) begin
        s1_d   <= lane_d;
        s1_tag <= gnt;
      end

      if (vld_pipe[1]) begin
        s2_pa  <= pa_c;
        s2_pb  <= pb_c;
        s2_tag <= s1_tag;
      end

      // Result registers only move on a retiring operation, so they hold
      // the last delivered value between pulses.
      if (vld_pipe[2] && !flush) begin
        rsp_result <= res_c;
        rsp_ge0    <= ~res_c[RES_W-1];
      end
    end
  end

  assign busy = |vld_pipe;

endmodule

// File: tb/tb_cross_product_arbiter.sv
// Randomised bench for cross_product_arbiter with a queue-based reference model.
module tb_cross_product_arbiter;
  localparam int N  = 2;
  localparam int CW = 10;
  localparam int RW = 2*CW+2;

  logic                      clk = 1'b0;
  logic                      reset, flush;
  logic [N-1:0]              req, gnt, rsp_valid;
  logic [N-1:0][2*CW-1:0]    req_ref, req_p1, req_p2;
  logic [RW-1:0]             rsp_result;
  logic                      rsp_ge0, busy;

  cross_product_arbiter #(.NUM_REQ(N), .COORD_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .req        (req),
    .req_ref    (req_ref),
    .req_p1     (req_p1),
    .req_p2     (req_p2),
    .gnt        (gnt),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .rsp_ge0    (rsp_ge0),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ model
  typedef struct {
    int tag;
    int res;
    int age;   // edges since acceptance; 3 = on the response port
  } item_t;

  item_t        pq[$];
  int           m_ptr;
  int           last_res;
  logic         last_ge0;
  logic [N-1:0] gnt_seen;

  function automatic int pick(logic [N-1:0] r, int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic int xp(int g);
    int rx, ry, ax, ay, bx, by;
    rx = int'(req_ref[g][2*CW-1:CW]); ry = int'(req_ref[g][CW-1:0]);
    ax = int'(req_p1[g][2*CW-1:CW]);  ay = int'(req_p1[g][CW-1:0]);
    bx = int'(req_p2[g][2*CW-1:CW]);  by = int'(req_p2[g][CW-1:0]);
    return (ax - rx) * (by - ry) - (bx - rx) * (ay - ry);
  endfunction

  function automatic int rc();
    int s;
    s = int'($urandom_range(7));
    if (s == 0) return 0;
    if (s == 1) return 1023;
    return int'($urandom_range(1023));
  endfunction

  task automatic model_reset();
    pq.delete();
    m_ptr    = 0;
    last_res = 0;
    last_ge0 = 1'b0;
  endtask

  task automatic new_op(int i, int rx, int ry, int ax, int ay, int bx, int by);
    req_ref[i] = {rx[CW-1:0], ry[CW-1:0]};
    req_p1[i]  = {ax[CW-1:0], ay[CW-1:0]};
    req_p2[i]  = {bx[CW-1:0], by[CW-1:0]};
    req[i]     = 1'b1;
  endtask

  task automatic rnd_op(int i);
    new_op(i, rc(), rc(), rc(), rc(), rc(), rc());
  endtask

  // One clock: check the combinational grant mid-cycle, advance the model
  // at the rising edge, then check the registered outputs.
  task automatic cycle();
    int           g;
    logic [N-1:0] eg, ev;
    logic [RW-1:0] er;
    item_t        nq[$];
    item_t        t;
    @(negedge clk);
    #1;
    g  = flush ? -1 : pick(req, m_ptr);
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    check("gnt", gnt, eg);
    gnt_seen = gnt;
    @(posedge clk);
    if (flush) pq.delete();
    else begin
      foreach (pq[j])
        if (pq[j].age < 3) begin
          t = pq[j];
          t.age++;
          nq.push_back(t);
        end
      if (g >= 0) begin
        t.tag = g; t.res = xp(g); t.age = 1;
        nq.push_back(t);
        m_ptr = (g + 1) % N;
      end
      pq = nq;
    end
    ev = '0;
    foreach (pq[j])
      if (pq[j].age == 3) begin
        ev[pq[j].tag] = 1'b1;
        last_res = pq[j].res;
        last_ge0 = (pq[j].res >= 0);
      end
    #1;
    er = last_res[RW-1:0];
    check("rsp_valid", rsp_valid, ev);
    check("rsp_result", rsp_result, er);
    check("rsp_ge0", rsp_ge0, last_ge0);
    check("busy", busy, pq.size() != 0);
  endtask

  // Single operation from requester 0 with a known answer.
  task automatic dop(int rx, int ry, int ax, int ay, int bx, int by, int exp);
    logic [RW-1:0] er;
    er = exp[RW-1:0];
    req = '0;
    new_op(0, rx, ry, ax, ay, bx, by);
    cycle();
    check("dir_gnt", gnt_seen, 2'b01);
    req = '0;
    cycle();
    cycle();
    check("dir_vld", rsp_valid, 2'b01);
    check("dir_res", rsp_result, er);
    check("dir_ge0", rsp_ge0, exp >= 0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; req = '0;
    req_ref = '0; req_p1 = '0; req_p2 = '0;
    gnt_seen = '0;
    model_reset();
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_vld", rsp_valid, 0);
    check("rst_res", rsp_result, 0);
    check("rst_ge0", rsp_ge0, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    // Both requesting continuously: strict alternation from pointer 0.
    rnd_op(0); rnd_op(1);
    for (int k = 0; k < 6; k++) begin
      cycle();
      check("rr_gnt", gnt_seen, (k % 2) ? 2'b10 : 2'b01);
      for (int i = 0; i < N; i++) if (gnt_seen[i]) rnd_op(i);
    end
    req = '0;
    repeat (4) cycle();

    // Known answers, including coordinate extremes.
    dop(0, 0, 10, 0, 0, 10, 100);
    dop(0, 0, 0, 10, 10, 0, -100);
    dop(0, 0, 5, 5, 9, 9, 0);
    dop(1023, 1023, 0, 1023, 1023, 0, 1046529);
    dop(0, 0, 0, 1023, 1023, 0, -1046529);
    dop(1023, 1023, 0, 0, 1023, 0, 1046529);
    req = '0;
    repeat (2) cycle();

    // Three back-to-back acceptances, then flush at the following edge.
    rnd_op(0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      rnd_op(0);
    end
    check("fl_first", rsp_valid, 2'b01);
    req = '0; flush = 1'b1;
    cycle();
    flush = 1'b0;
    check("fl_busy", busy, 0);
    check("fl_vld", rsp_valid, 0);
    repeat (3) cycle();

    // Random traffic with occasional flush and one asynchronous reset.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++)
        if (!req[i] && $urandom_range(99) < 60) rnd_op(i);
      flush = ($urandom_range(99) < 4);
      cycle();
      flush = 1'b0;
      for (int i = 0; i < N; i++)
        if (gnt_seen[i]) begin
          if ($urandom_range(1) == 1) rnd_op(i);
          else req[i] = 1'b0;
        end
      if (c == 700) begin
        rnd_op(0); rnd_op(1);
        #2 reset = 1'b1;
        #1;
        check("arst_gnt", gnt, 0);
        check("arst_vld", rsp_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_res", rsp_result, 0);
        model_reset();
        @(posedge clk);
        #2 reset = 1'b0;
        cycle();
        check("arst_first_gnt", gnt_seen, 2'b01);
        for (int i = 0; i < N; i++) if (gnt_seen[i]) rnd_op(i);
      end
    end
    req = '0;
    repeat (5) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
